// File: rtl/divider_pkg.sv
// Shared definitions for the iterative restoring divider: FSM states,
// width and iteration constants, and the divide-by-zero quotient.
package divider_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // One quotient bit per iteration, so iterations equal the operand width.
    localparam int ITER_COUNT = DEFAULT_DATA_WIDTH;
    localparam int CNT_W      = $clog2(ITER_COUNT);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITER_COUNT - 1);

    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/divider_step.sv
// Single combinational restoring-division step: shift {rem,quo} left by one,
// trial-subtract the divisor, keep the difference when it does not go negative.
module divider_step
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = ITER_COUNT
) (
    input  logic [DATA_WIDTH:0]   rem_in,
    input  logic [DATA_WIDTH-1:0] quo_in,
    input  logic [DATA_WIDTH-1:0] dvs_in,
    output logic [DATA_WIDTH:0]   rem_out,
    output logic [DATA_WIDTH-1:0] quo_out
);

    logic [DATA_WIDTH+1:0] shifted;
    logic                  keep;

    // Trial subtraction expressed as a compare so no borrow bit is left dangling.
    always_comb begin
        shifted = {rem_in, quo_in[DATA_WIDTH-1]};
        keep    = (shifted >= {2'b00, dvs_in});
        rem_out = keep ? (shifted[DATA_WIDTH:0] - {1'b0, dvs_in}) : shifted[DATA_WIDTH:0];
        quo_out = {quo_in[DATA_WIDTH-2:0], keep};
    end

endmodule

// File: rtl/divider_unit.sv
// Iterative 32-bit restoring divider for DIV/DIVU on the HI/LO path.
// Works on magnitudes; signs are re-applied in the FIX state. Quotient goes
// to low_output, remainder to high_output, both held until rewritten.
module divider_unit
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = ITER_COUNT
) (
    input  logic                  clock_signal,
    input  logic                  reset_signal,
    input  logic                  start_signal,
    input  logic                  signed_division,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy_signal,
    output logic                  done_signal,
    output logic [DATA_WIDTH-1:0] low_output,
    output logic [DATA_WIDTH-1:0] high_output
);

    function automatic logic [DATA_WIDTH-1:0] magnitude(
        input logic signed [DATA_WIDTH-1:0] value,
        input logic                         use_sign
    );
        return (use_sign && value[DATA_WIDTH-1]) ? (~value + 1'b1) : value;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] apply_sign(
        input logic [DATA_WIDTH-1:0] mag,
        input logic                  negate
    );
        return negate ? (~mag + 1'b1) : mag;
    endfunction

    div_state_e state_q, state_d;

    logic [DATA_WIDTH:0]   rem_q, rem_nxt;
    logic [DATA_WIDTH-1:0] quo_q, quo_nxt;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic                  quo_neg_q, rem_neg_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  accept;
    logic                  divisor_zero;

    assign accept       = start_signal && ((state_q == IDLE) || (state_q == DONE));
    assign divisor_zero = (divisor == '0);

    divider_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .rem_in (rem_q),
        .quo_in (quo_q),
        .dvs_in (dvs_q),
        .rem_out(rem_nxt),
        .quo_out(quo_nxt)
    );

    // State register.
    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; a zero divisor skips straight to DONE.
    always_comb begin
        state_d     = state_q;
        busy_signal = 1'b0;
        done_signal = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = divisor_zero ? DONE : ITER;
                end
            end
            ITER: begin
                busy_signal = 1'b1;
                if (cnt_q == LAST_COUNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_signal = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                done_signal = 1'b1;
                if (accept) begin
                    state_d = divisor_zero ? DONE : ITER;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Working registers: latch magnitudes and signs on accept, step in ITER.
    always_ff @(posedge clock_signal) begin
        if (accept) begin
            rem_q     <= '0;
            quo_q     <= magnitude(dividend, signed_division);
            dvs_q     <= magnitude(divisor, signed_division);
            quo_neg_q <= signed_division & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
            rem_neg_q <= signed_division & dividend[DATA_WIDTH-1];
        end else if (state_q == ITER) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

    // Iteration counter and result registers; reset clears them even mid-operation.
    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            cnt_q       <= '0;
            low_output  <= '0;
            high_output <= '0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if (state_q == ITER) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (accept && divisor_zero) begin
                low_output  <= DIV_ZERO_QUOTIENT;
                high_output <= dividend;
            end else if (state_q == FIX) begin
                low_output  <= apply_sign(quo_q, quo_neg_q);
                high_output <= apply_sign(rem_q[DATA_WIDTH-1:0], rem_neg_q);
            end
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: the driver pushes expected results,
// a negedge monitor pops and compares whenever done_signal is seen.
module tb_divider_unit;

    logic        clock_signal = 1'b0;
    logic        reset_signal;
    logic        start_signal;
    logic        signed_division;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy_signal;
    logic        done_signal;
    logic [31:0] low_output;
    logic [31:0] high_output;

    divider_unit dut (
        .clock_signal   (clock_signal),
        .reset_signal   (reset_signal),
        .start_signal   (start_signal),
        .signed_division(signed_division),
        .dividend       (dividend),
        .divisor        (divisor),
        .busy_signal    (busy_signal),
        .done_signal    (done_signal),
        .low_output     (low_output),
        .high_output    (high_output)
    );

    always #5 clock_signal = ~clock_signal;

    int unsigned cyc = 0;
    always @(posedge clock_signal) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int unsigned cyc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division, 64-bit for signed so -2^31/-1 is well defined.
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sbv, q, r;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = sa / sbv;
            r   = sa % sbv;
            lo  = q[31:0];
            hi  = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock_signal) begin
        if (!reset_signal && done_signal) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=%h/%h expected=no_done", low_output, high_output);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.nm, "_low"}, low_output, mon_e.lo);
                chk({mon_e.nm, "_high"}, high_output, mon_e.hi);
                chk({mon_e.nm, "_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    // Called at a negedge: present a start and record the expected result and done cycle.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] lo, input logic [31:0] hi, input string nm);
        exp_t e;
        signed_division = sgn;
        dividend        = a;
        divisor         = b;
        start_signal    = 1'b1;
        e.lo  = lo;
        e.hi  = hi;
        e.nm  = nm;
        e.cyc = cyc + 1 + ((b == 32'd0) ? 0 : 33);
        sb.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40 && !done_signal; i++) @(negedge clock_signal);
        if (!done_signal) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done expected=done", nm);
            sb.delete();
        end
    endtask

    // Issue one operation and return at the negedge where done is high.
    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi, input string nm);
        start_op(sgn, a, b, lo, hi, nm);
        @(negedge clock_signal);
        start_signal = 1'b0;
        dividend     = $urandom;
        divisor      = $urandom;
        wait_done(nm);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = $urandom;
            1: v = $urandom_range(0, 20);
            2: v = -$urandom_range(1, 20);
            3: v = 32'h8000_0000;
            4: v = 32'hFFFF_FFFF;
            default: v = $urandom >> $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] lo, hi, a, b;
        logic        sgn;

        reset_signal    = 1'b1;
        start_signal    = 1'b0;
        signed_division = 1'b0;
        dividend        = '0;
        divisor         = '0;
        repeat (3) @(negedge clock_signal);
        chk("reset_busy", busy_signal, 0);
        chk("reset_done", done_signal, 0);
        chk("reset_low", low_output, 0);
        chk("reset_high", high_output, 0);
        reset_signal = 1'b0;
        @(negedge clock_signal);

        // Latency and busy profile for DIVU 100/7.
        start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7");
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock_signal);
            if (k == 1) start_signal = 1'b0;
            chk($sformatf("busy_c%0d", k), busy_signal, (k <= 33) ? 1 : 0);
            chk($sformatf("done_c%0d", k), done_signal, (k == 34) ? 1 : 0);
        end

        // Directed cases, issued back-to-back in each DONE cycle.
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "div_7_m2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "div_ovf");
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, "divu_max_1");
        do_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "divu_zero");
        do_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, "div_zero");
        do_op(1'b1, 32'h8000_0005, 32'd0, 32'hFFFF_FFFF, 32'h8000_0005, "div_zero_neg");
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "divu_big");
        @(negedge clock_signal);

        // Reset ten cycles into an operation aborts it.
        start_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, "rst_abort");
        @(negedge clock_signal);
        start_signal = 1'b0;
        repeat (9) @(negedge clock_signal);
        reset_signal = 1'b1;
        @(negedge clock_signal);
        chk("abort_busy", busy_signal, 0);
        chk("abort_done", done_signal, 0);
        chk("abort_low", low_output, 0);
        chk("abort_high", high_output, 0);
        sb.delete();
        reset_signal = 1'b0;
        repeat (2) @(negedge clock_signal);

        // A start while busy must be ignored.
        start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, "ignore_start");
        @(negedge clock_signal);
        start_signal = 1'b0;
        repeat (4) @(negedge clock_signal);
        start_signal    = 1'b1;
        signed_division = 1'b1;
        dividend        = 32'hFFFF_FFCE;
        divisor         = 32'd3;
        @(negedge clock_signal);
        start_signal = 1'b0;
        wait_done("ignore_start");
        repeat (5) @(negedge clock_signal);
        chk("held_low", low_output, 32'd14);
        chk("held_high", high_output, 32'd2);
        chk("held_busy", busy_signal, 0);

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 1500; i++) begin
            sgn = $urandom_range(0, 1);
            a   = rnd_operand();
            b   = rnd_operand();
            model(sgn, a, b, lo, hi);
            do_op(sgn, a, b, lo, hi, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock_signal);
        end

        repeat (3) @(negedge clock_signal);
        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
